qeciphy_crc_scheduler: RTL and testbench

Transmit-side slot scheduler that sequences the multi-channel CRC compute engine and the TX word mux. It divides the 64-bit TX word stream into FAW, data and CRC slots. It drives the `faw_boundary`/`crc_boundary` strobes the CRC engine needs to restart its staggered enable/reset pipelines, and tells the TX mux which word source to select each cycle. It sits between the link-training controller (link up / resync requests) and the TX datapath.

---
 rtl/qeciphy_pkg.sv | 15 +
 rtl/qeciphy_crc_scheduler.sv | 120 ++++++++++++
 tb/tb_qeciphy_crc_scheduler.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/qeciphy_pkg.sv
// Types and constants shared by the TX slot scheduler, the TX word mux and the RX checker.
package qeciphy_pkg;

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_FAW  = 2'd1,
    SLOT_DATA = 2'd2,
    SLOT_CRC  = 2'd3
  } slot_t;

  localparam int unsigned DATA_PER_CRC = 6;
  localparam int unsigned FRAME_CNT_W  = 8;
  localparam int unsigned DATA_IDX_W   = 3;

endpackage

// File: rtl/qeciphy_crc_scheduler.sv
// TX slot scheduler: splits the word stream into FAW / DATA / CRC slots and
// strobes the CRC engine boundaries and the TX mux source each cycle.
module qeciphy_crc_scheduler
  import qeciphy_pkg::*;
#(
  parameter int unsigned CRCS_PER_FAW = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   link_up_i,
  input  logic                   resync_i,
  output slot_t                  slot_o,
  output logic                   faw_boundary_o,
  output logic                   crc_boundary_o,
  output logic                   data_ready_o,
  output logic [DATA_IDX_W-1:0]  data_idx_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FAW,
    ST_DATA,
    ST_CRC
  } state_t;

  localparam logic [DATA_IDX_W-1:0]  LAST_IDX   = DATA_IDX_W'(DATA_PER_CRC - 1);
  localparam logic [FRAME_CNT_W-1:0] CNT_TARGET = FRAME_CNT_W'(CRCS_PER_FAW);
  localparam logic [FRAME_CNT_W-1:0] CNT_ONE    = FRAME_CNT_W'(1);
  localparam logic [DATA_IDX_W-1:0]  IDX_ONE    = DATA_IDX_W'(1);

  state_t                 state_q;
  state_t                 state_d;
  logic                   resync_pend_q;
  logic                   resync_pend_d;
  logic [DATA_IDX_W-1:0]  data_idx_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_d;
  slot_t                  slot_d;

  // Next state, next counters and the slot decode of the next state.
  always_comb begin
    state_d       = state_q;
    resync_pend_d = resync_pend_q;
    data_idx_d    = '0;
    frame_cnt_d   = frame_cnt_o;
    slot_d        = SLOT_IDLE;

    if (!link_up_i) begin
      state_d       = ST_IDLE;
      resync_pend_d = 1'b0;
      frame_cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d       = ST_FAW;
          resync_pend_d = 1'b0;
        end
        ST_FAW: begin
          // A resync during FAW is dropped: this FAW already realigns.
          state_d       = ST_DATA;
          resync_pend_d = 1'b0;
          frame_cnt_d   = '0;
        end
        ST_DATA: begin
          resync_pend_d = resync_pend_q | resync_i;
          if (data_idx_o == LAST_IDX) begin
            state_d = ST_CRC;
          end else begin
            data_idx_d = data_idx_o + IDX_ONE;
          end
        end
        ST_CRC: begin
          frame_cnt_d = frame_cnt_o + CNT_ONE;
          if ((frame_cnt_d == CNT_TARGET) || resync_pend_q || resync_i) begin
            state_d       = ST_FAW;
            resync_pend_d = 1'b0;
          end else begin
            state_d = ST_DATA;
          end
        end
        default: begin
          state_d       = ST_IDLE;
          resync_pend_d = 1'b0;
          frame_cnt_d   = '0;
        end
      endcase
    end

    unique case (state_d)
      ST_FAW:  slot_d = SLOT_FAW;
      ST_DATA: slot_d = SLOT_DATA;
      ST_CRC:  slot_d = SLOT_CRC;
      default: slot_d = SLOT_IDLE;
    endcase
  end

  // State and registered outputs; outputs are a pure decode of the next state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q        <= ST_IDLE;
      resync_pend_q  <= 1'b0;
      slot_o         <= SLOT_IDLE;
      faw_boundary_o <= 1'b0;
      crc_boundary_o <= 1'b0;
      data_ready_o   <= 1'b0;
      data_idx_o     <= '0;
      frame_cnt_o    <= '0;
    end else begin
      state_q        <= state_d;
      resync_pend_q  <= resync_pend_d;
      slot_o         <= slot_d;
      faw_boundary_o <= (state_d == ST_FAW);
      crc_boundary_o <= (state_d == ST_CRC);
      data_ready_o   <= (state_d == ST_DATA);
      data_idx_o     <= data_idx_d;
      frame_cnt_o    <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_qeciphy_crc_scheduler.sv
// Bench for qeciphy_crc_scheduler: table vectors, directed corner sequences and
// random link/resync traffic against a frame-position reference model.
module tb_qeciphy_crc_scheduler;
  import qeciphy_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       link_up;
  logic       resync;
  slot_t      slot_w [2];
  logic       faw_w  [2];
  logic       crc_w  [2];
  logic       rdy_w  [2];
  logic [2:0] idx_w  [2];
  logic [7:0] cnt_w  [2];

  qeciphy_crc_scheduler #(.CRCS_PER_FAW(2)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .link_up_i(link_up), .resync_i(resync),
    .slot_o(slot_w[0]), .faw_boundary_o(faw_w[0]), .crc_boundary_o(crc_w[0]),
    .data_ready_o(rdy_w[0]), .data_idx_o(idx_w[0]), .frame_cnt_o(cnt_w[0])
  );

  qeciphy_crc_scheduler u_dut64 (
    .clk_i(clk), .rst_n_i(rst_n), .link_up_i(link_up), .resync_i(resync),
    .slot_o(slot_w[1]), .faw_boundary_o(faw_w[1]), .crc_boundary_o(crc_w[1]),
    .data_ready_o(rdy_w[1]), .data_idx_o(idx_w[1]), .frame_cnt_o(cnt_w[1])
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: position within the frame (0 = FAW, then groups of 7 slots).
  bit m_idle [2];
  int m_pos  [2];
  bit m_pend [2];
  int m_cnt  [2];
  int since_crc [2];

  typedef struct {
    bit link;
    bit resync;
    int slot;
    int idx;
    int cnt;
  } vec_t;
  vec_t vt [20];

  function automatic int n_of(int i);
    return (i == 0) ? 2 : 64;
  endfunction

  function automatic int m_slot(int i);
    if (m_idle[i]) return 0;
    if (m_pos[i] == 0) return 1;
    return (((m_pos[i] - 1) % 7) < 6) ? 2 : 3;
  endfunction

  function automatic int m_idx(int i);
    return (m_slot(i) == 2) ? ((m_pos[i] - 1) % 7) : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0d required %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_idle[i] = 1'b1;
      m_pos[i]  = 0;
      m_pend[i] = 1'b0;
      m_cnt[i]  = 0;
      since_crc[i] = -1;
    end
  endtask

  task automatic model_step(input int i);
    if (!link_up) begin
      m_idle[i] = 1'b1;
      m_pos[i]  = 0;
      m_pend[i] = 1'b0;
      m_cnt[i]  = 0;
    end else if (m_idle[i]) begin
      m_idle[i] = 1'b0;
      m_pos[i]  = 0;
      m_pend[i] = 1'b0;
    end else if (m_pos[i] == 0) begin
      m_pos[i]  = 1;
      m_cnt[i]  = 0;
      m_pend[i] = 1'b0;
    end else if (((m_pos[i] - 1) % 7) < 6) begin
      m_pend[i] = m_pend[i] | resync;
      m_pos[i]  = m_pos[i] + 1;
    end else begin
      m_cnt[i] = m_cnt[i] + 1;
      if (m_cnt[i] == n_of(i) || m_pend[i] || resync) begin
        m_pos[i]  = 0;
        m_pend[i] = 1'b0;
      end else begin
        m_pos[i] = m_pos[i] + 1;
      end
    end
  endtask

  task automatic check_model(input int i);
    int s;
    s = m_slot(i);
    chk($sformatf("u%0d.slot", i), slot_w[i], s);
    chk($sformatf("u%0d.faw", i), faw_w[i], (s == 1) ? 1 : 0);
    chk($sformatf("u%0d.crc", i), crc_w[i], (s == 3) ? 1 : 0);
    chk($sformatf("u%0d.ready", i), rdy_w[i], (s == 2) ? 1 : 0);
    chk($sformatf("u%0d.idx", i), idx_w[i], m_idx(i));
    chk($sformatf("u%0d.cnt", i), cnt_w[i], m_cnt[i]);
  endtask

  // Engine crc_valid cadence: CRC strobes inside one frame are 7 cycles apart.
  task automatic cadence(input int i);
    if (m_idle[i] || faw_w[i] === 1'b1) begin
      since_crc[i] = -1;
    end else if (crc_w[i] === 1'b1) begin
      if (since_crc[i] >= 0) chk($sformatf("u%0d.crc_gap", i), since_crc[i] + 1, 7);
      since_crc[i] = 0;
    end else if (since_crc[i] >= 0) begin
      since_crc[i] = since_crc[i] + 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      model_reset();
    end else begin
      model_step(0);
      model_step(1);
    end
    #2;
    check_model(0);
    check_model(1);
    cadence(0);
    cadence(1);
  endtask

  task automatic wait_model(input int i, input int slot, input int idx, input int cnt,
                            input string name);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (m_slot(i) == slot && m_idx(i) == idx && m_cnt[i] == cnt) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk({"wait_", name}, found, 1);
  endtask

  task automatic chk_idle(input int i, input string name);
    chk({name, ".slot"}, slot_w[i], 0);
    chk({name, ".faw"}, faw_w[i], 0);
    chk({name, ".crc"}, crc_w[i], 0);
    chk({name, ".ready"}, rdy_w[i], 0);
    chk({name, ".idx"}, idx_w[i], 0);
    chk({name, ".cnt"}, cnt_w[i], 0);
  endtask

  initial begin
    int nfaw;
    rst_n   = 1'b0;
    link_up = 1'b1;
    resync  = 1'b0;
    model_reset();

    // Expected slot sequence for CRCS_PER_FAW=2 after reset release with link up.
    vt[0] = '{1'b1, 1'b0, 1, 0, 0};
    for (int d = 0; d < 6; d++) vt[1 + d] = '{1'b1, 1'b0, 2, d, 0};
    vt[7] = '{1'b1, 1'b0, 3, 0, 0};
    for (int d = 0; d < 6; d++) vt[8 + d] = '{1'b1, 1'b0, 2, d, 1};
    vt[14] = '{1'b1, 1'b0, 3, 0, 1};
    vt[15] = '{1'b1, 1'b0, 1, 0, 2};
    vt[16] = '{1'b1, 1'b0, 2, 0, 0};
    vt[17] = '{1'b0, 1'b1, 0, 0, 0};
    vt[18] = '{1'b1, 1'b0, 1, 0, 0};
    vt[19] = '{1'b1, 1'b0, 2, 0, 0};

    repeat (2) @(posedge clk);
    #2;
    chk_idle(0, "rst0");
    chk_idle(1, "rst1");
    rst_n = 1'b1;

    for (int k = 0; k < 20; k++) begin
      link_up = vt[k].link;
      resync  = vt[k].resync;
      tick();
      chk($sformatf("vec%0d.slot", k), slot_w[0], vt[k].slot);
      chk($sformatf("vec%0d.idx", k), idx_w[0], vt[k].idx);
      chk($sformatf("vec%0d.cnt", k), cnt_w[0], vt[k].cnt);
      chk($sformatf("vec%0d.faw", k), faw_w[0], (vt[k].slot == 1) ? 1 : 0);
      chk($sformatf("vec%0d.crc", k), crc_w[0], (vt[k].slot == 3) ? 1 : 0);
    end
    link_up = 1'b1;
    resync  = 1'b0;

    // Resync pulsed in DATA idx 0 of group 3: group finishes, CRC, then FAW.
    wait_model(1, 2, 0, 2, "grp3");
    resync = 1'b1;
    tick();
    resync = 1'b0;
    repeat (4) tick();
    chk("rs.d5", idx_w[1], 5);
    tick();
    chk("rs.crc", slot_w[1], 3);
    tick();
    chk("rs.faw", slot_w[1], 1);
    chk("rs.cnt", cnt_w[1], 3);
    tick();
    chk("rs.d0", slot_w[1], 2);
    chk("rs.cnt0", cnt_w[1], 0);

    // Link drop in DATA idx 3, then re-assert.
    wait_model(1, 2, 3, 0, "idx3");
    link_up = 1'b0;
    tick();
    chk_idle(1, "ld");
    link_up = 1'b1;
    tick();
    chk("ld.faw", slot_w[1], 1);
    chk("ld.cnt", cnt_w[1], 0);

    // Resync coincident with the natural last CRC: exactly one FAW.
    wait_model(0, 3, 0, 1, "lastcrc");
    resync = 1'b1;
    tick();
    resync = 1'b0;
    chk("co.faw", slot_w[0], 1);
    nfaw = 0;
    repeat (14) begin
      tick();
      if (faw_w[0] === 1'b1) nfaw++;
    end
    chk("co.nfaw", nfaw, 0);
    tick();
    chk("co.next_faw", slot_w[0], 1);

    // Asynchronous reset in the middle of a CRC slot.
    wait_model(0, 3, 0, 0, "crc");
    #1 rst_n = 1'b0;
    #1;
    chk_idle(0, "ar0");
    chk_idle(1, "ar1");
    model_reset();
    tick();
    #1 rst_n = 1'b1;
    tick();
    chk("ar.faw", slot_w[0], 1);
    chk("ar.cnt", cnt_w[0], 0);

    // Random link and resync traffic.
    repeat (3000) begin
      link_up = ($urandom_range(0, 63) != 0);
      resync  = ($urandom_range(0, 24) == 0);
      tick();
    end
    link_up = 1'b1;
    resync  = 1'b0;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
